// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared constants for the IF/ID instruction queue
package if_id_pkg;

  // Default entry field widths
  localparam int INST_W  = 32;
  localparam int IADDR_W = 32;
  localparam int IFLAG_W = 8;

  // Instruction presented to decode when the queue is empty
  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h00000001;

  // Hold level encodings driven by ctrl
  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IF   = 3'b010;
  localparam logic [2:0] HOLD_ID   = 3'b011;

endpackage

// File: rtl/if_id_qptr.sv
// rtl/if_id_qptr.sv - wrapping queue pointer, counts 0..DEPTH-1
module if_id_qptr #(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] r_ptr;

  // Advance on inc, wrapping after the last entry; clear wins over inc
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - DEPTH-entry in-order IF/ID queue with hold and flush
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int               DATA_W     = INST_W,
  parameter int               ADDR_W     = IADDR_W,
  parameter int               INT_W      = IFLAG_W,
  parameter int               DEPTH      = 2,
  parameter logic [2:0]       HOLD_LEVEL = HOLD_IF,
  parameter logic [DATA_W-1:0] NOP_INST  = NOP_INST_DEF,
  localparam int              CNT_W      = $clog2(DEPTH + 1),
  localparam int              PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        hold_flag_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] r_inst [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [INT_W-1:0]  r_flag [DEPTH];
  logic [CNT_W-1:0]  r_count;

  logic [PTR_W-1:0]  w_wr_ptr;
  logic [PTR_W-1:0]  w_rd_ptr;
  logic              w_hold_en;
  logic              w_valid;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;

  // A full queue refuses input even if the head leaves this cycle, which
  // keeps ready_o independent of hold and of the pop decision.
  assign w_hold_en = (hold_flag_i >= HOLD_LEVEL);
  assign w_valid   = (r_count != '0);
  assign w_ready   = (r_count < CNT_W'(DEPTH)) && !flush_i;
  assign w_push    = valid_i && w_ready;
  assign w_pop     = w_valid && !w_hold_en;

  if_id_qptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_push),
    .clr   (flush_i),
    .ptr_o (w_wr_ptr)
  );

  if_id_qptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_pop),
    .clr   (flush_i),
    .ptr_o (w_rd_ptr)
  );

  // Entry storage, written on push only; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[w_wr_ptr] <= inst_i;
      r_addr[w_wr_ptr] <= inst_addr_i;
      r_flag[w_wr_ptr] <= int_flag_i;
    end
  end

  // Occupancy: push and pop in the same cycle cancel out
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign ready_o     = w_ready;
  assign valid_o     = w_valid;
  assign count_o     = r_count;
  assign inst_o      = w_valid ? r_inst[w_rd_ptr] : NOP_INST;
  assign inst_addr_o = w_valid ? r_addr[w_rd_ptr] : '0;
  assign int_flag_o  = w_valid ? r_flag[w_rd_ptr] : '0;

endmodule
